// File: rtl/scd_core.sv
// scd_core: 16-bit multi-cycle CPU with a 128x16 unified memory.
// A loader fills memory while rst is high; halted flags program end.
module scd_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_we,
    input  logic [6:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic        halted,
    output logic [7:0]  dbg_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_pc;
    logic [7:0]  w_pc_nxt;
    logic [15:0] r_ir;
    logic [15:0] r_rf [16];
    logic [15:0] r_mem [128];
    logic [15:0] r_mem_out;
    logic        r_halted;

    logic [15:0] w_ins;
    logic [3:0]  w_op;
    logic [3:0]  w_d;
    logic [3:0]  w_a;
    logic [3:0]  w_b;
    logic [7:0]  w_imm;
    logic [15:0] w_ra;
    logic [15:0] w_rb;
    logic [15:0] w_rd;
    logic [15:0] w_alu;
    logic [6:0]  w_ea_word;
    logic [6:0]  w_mem_word;
    logic        w_mem_we;
    logic        w_rf_we;
    logic [15:0] w_rf_wd;
    logic        w_halt_set;

    // In EXEC decode straight from the memory output; IR serves WB.
    assign w_ins = (r_state == S_EXEC) ? r_mem_out : r_ir;
    assign w_op  = w_ins[15:12];
    assign w_d   = w_ins[11:8];
    assign w_a   = w_ins[7:4];
    assign w_b   = w_ins[3:0];
    assign w_imm = w_ins[7:0];
    assign w_ra  = r_rf[w_a];
    assign w_rb  = r_rf[w_b];
    assign w_rd  = r_rf[w_d];

    // Effective address is an 8-bit byte address; bit 0 selects nothing.
    assign w_ea_word = 7'((w_ra[7:0] + w_rb[7:0]) >> 1);

    assign halted = r_halted;
    assign dbg_pc = r_pc;

    // ALU result for opcodes 1..7, mod 2^16, no flags.
    always_comb begin
        w_alu = '0;
        case (w_op)
            4'h1:    w_alu = w_ra + w_rb;
            4'h2:    w_alu = w_ra - w_rb;
            4'h3:    w_alu = w_ra & w_rb;
            4'h4:    w_alu = w_ra | w_rb;
            4'h5:    w_alu = w_ra ^ w_rb;
            4'h6:    w_alu = w_ra << w_rb[3:0];
            4'h7:    w_alu = w_ra >> w_rb[3:0];
            default: w_alu = '0;
        endcase
    end

    // Next-state, PC, memory bus and register write control.
    always_comb begin
        w_next     = r_state;
        w_pc_nxt   = r_pc;
        w_mem_word = r_pc[7:1];
        w_mem_we   = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_wd    = w_alu;
        w_halt_set = 1'b0;
        unique case (r_state)
            S_FETCH: w_next = S_EXEC;
            S_EXEC: begin
                w_next   = S_FETCH;
                w_pc_nxt = r_pc + 8'd2;
                case (w_op)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7: w_rf_we = 1'b1;
                    4'h8: w_pc_nxt = w_imm;
                    4'h9: begin
                        if (w_rd == 16'h0000) w_pc_nxt = w_imm;
                    end
                    4'hC: begin
                        w_halt_set = 1'b1;
                        w_next     = S_HALT;
                    end
                    4'hD: begin
                        w_mem_word = w_ea_word;
                        w_mem_we   = 1'b1;
                    end
                    4'hE: begin
                        w_mem_word = w_ea_word;
                        w_next     = S_WB;
                    end
                    4'hF: begin
                        w_rf_we = 1'b1;
                        w_rf_wd = {8'h00, w_imm};
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                w_rf_we = 1'b1;
                w_rf_wd = r_mem_out;
                w_next  = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
        endcase
    end

    // Memory: loader owns the write port in reset, core otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (ld_we) r_mem[ld_addr] <= ld_data;
        end else if (w_mem_we) begin
            r_mem[w_mem_word] <= w_rd;
        end
        r_mem_out <= r_mem[w_mem_word];
    end

    // Control state: FSM, PC, IR and halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_nxt;
            if (r_state == S_EXEC) r_ir <= r_mem_out;
            if (w_halt_set) r_halted <= 1'b1;
        end
    end

    // Register file: cleared in reset, one write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else if (w_rf_we) begin
            r_rf[w_d] <= w_rf_wd;
        end
    end

endmodule

// File: tb/tb_scd_core.sv
// tb_scd_core: directed and random programs against an
// instruction-level reference model of the SCD ISA.
module tb_scd_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_we = 1'b0;
    logic [6:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        halted;
    logic [7:0]  dbg_pc;

    always #5 clk = ~clk;

    scd_core dut (
        .clk     (clk),
        .rst     (rst),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .halted  (halted),
        .dbg_pc  (dbg_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] img   [128];
    logic [15:0] m_mem [128];
    logic [15:0] m_rf  [16];
    logic [7:0]  m_pc;
    logic        m_halted;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_img(input logic [15:0] v);
        for (int i = 0; i < 128; i++) img[i] = v;
    endtask

    // Hold reset, load the whole image, reset the model.
    task automatic load_img();
        rst = 1'b1;
        for (int i = 0; i < 128; i++) begin
            ld_we   = 1'b1;
            ld_addr = 7'(i);
            ld_data = img[i];
            tick();
            m_mem[i] = img[i];
        end
        ld_we = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_pc     = '0;
        m_halted = 1'b0;
        chk("rst_pc", dbg_pc, 32'h0);
        chk("rst_halted", halted, 32'h0);
        chk("rst_r1", dut.r_rf[1], 32'h0);
    endtask

    // Execute one instruction of the ISA; report its cycle count.
    task automatic m_step(output int cyc);
        logic [15:0] ins;
        logic [3:0]  op;
        logic [3:0]  d;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  imm;
        logic [7:0]  ea;
        ins = m_mem[m_pc[7:1]];
        op  = ins[15:12];
        d   = ins[11:8];
        x   = m_rf[ins[7:4]];
        y   = m_rf[ins[3:0]];
        imm = ins[7:0];
        ea  = 8'(x + y);
        cyc = 2;
        m_pc = m_pc + 8'd2;
        case (op)
            4'h1: m_rf[d] = x + y;
            4'h2: m_rf[d] = x - y;
            4'h3: m_rf[d] = x & y;
            4'h4: m_rf[d] = x | y;
            4'h5: m_rf[d] = x ^ y;
            4'h6: m_rf[d] = x << y[3:0];
            4'h7: m_rf[d] = x >> y[3:0];
            4'h8: m_pc = imm;
            4'h9: if (m_rf[d] == 16'h0) m_pc = imm;
            4'hC: m_halted = 1'b1;
            4'hD: m_mem[ea[7:1]] = m_rf[d];
            4'hE: begin
                m_rf[d] = m_mem[ea[7:1]];
                cyc = 3;
            end
            4'hF: m_rf[d] = {8'h00, imm};
            default: ;
        endcase
    endtask

    task automatic run_instr(input int n, input string tag);
        int cyc;
        for (int k = 0; k < n; k++) begin
            if (m_halted) break;
            m_step(cyc);
            repeat (cyc) tick();
            chk({tag, "_pc"}, dbg_pc, m_pc);
            chk({tag, "_halt"}, halted, m_halted);
        end
    endtask

    task automatic cmp_all(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_r%0d", tag, i), dut.r_rf[i], m_rf[i]);
        for (int i = 0; i < 128; i++)
            if (dut.r_mem[i] !== m_mem[i]) bad++;
        chk({tag, "_mem_bad_words"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;

        // Basic load/store program
        fill_img(16'hC000);
        img[0] = 16'hF10A;
        img[1] = 16'hF204;
        img[2] = 16'hD212;
        img[3] = 16'hE312;
        img[4] = 16'hC000;
        load_img();
        rst = 1'b0;
        run_instr(1, "ls");
        chk("ls_r1", dut.r_rf[1], 32'h000A);
        run_instr(1, "ls");
        chk("ls_r2", dut.r_rf[2], 32'h0004);
        run_instr(1, "ls");
        chk("ls_mem7", dut.r_mem[7], 32'h0004);
        run_instr(1, "ls");
        chk("ls_r3", dut.r_rf[3], 32'h0004);
        run_instr(1, "ls");
        chk("ls_halted", halted, 32'h1);
        chk("ls_pc_halt", dbg_pc, 32'h0A);
        repeat (5) tick();
        chk("ls_halted_frozen", halted, 32'h1);
        chk("ls_pc_frozen", dbg_pc, 32'h0A);
        ld_we   = 1'b1;
        ld_addr = 7'd0;
        ld_data = 16'hFFFF;
        tick();
        ld_we = 1'b0;
        chk("ld_ignored", dut.r_mem[0], 32'hF10A);
        cmp_all("ls");

        // ALU
        fill_img(16'hC000);
        img[0] = 16'hF1FF;
        img[1] = 16'hF201;
        img[2] = 16'h1312;
        img[3] = 16'h2421;
        img[4] = 16'hF604;
        img[5] = 16'h6516;
        img[6] = 16'h7712;
        img[7] = 16'h5111;
        load_img();
        rst = 1'b0;
        run_instr(9, "alu");
        chk("alu_add", dut.r_rf[3], 32'h0100);
        chk("alu_sub", dut.r_rf[4], 32'hFF02);
        chk("alu_shl", dut.r_rf[5], 32'h0FF0);
        chk("alu_shr", dut.r_rf[7], 32'h007F);
        chk("alu_xor", dut.r_rf[1], 32'h0000);
        chk("alu_halted", halted, 32'h1);
        cmp_all("alu");

        // Branches and PC wrap
        fill_img(16'hC000);
        img[0]   = 16'h9020;
        img[16]  = 16'hF105;
        img[17]  = 16'h9140;
        img[18]  = 16'h80FE;
        img[127] = 16'h0000;
        load_img();
        rst = 1'b0;
        run_instr(1, "br");
        chk("bz_taken", dbg_pc, 32'h20);
        run_instr(1, "br");
        chk("li_pc", dbg_pc, 32'h22);
        run_instr(1, "br");
        chk("bz_fall", dbg_pc, 32'h24);
        run_instr(1, "br");
        chk("jmp_fe", dbg_pc, 32'hFE);
        run_instr(1, "br");
        chk("pc_wrap", dbg_pc, 32'h00);
        cmp_all("br");

        // EA wrap and store-then-load
        fill_img(16'hC000);
        img[0] = 16'hF181;
        img[1] = 16'hF25A;
        img[2] = 16'hD211;
        img[3] = 16'hE311;
        load_img();
        rst = 1'b0;
        run_instr(5, "mem");
        chk("ea_wrap_st", dut.r_mem[1], 32'h005A);
        chk("st_ld_fwd", dut.r_rf[3], 32'h005A);
        cmp_all("mem");

        // Reset during WB of an LD
        fill_img(16'hC000);
        img[0] = 16'hF106;
        img[1] = 16'hE210;
        img[2] = 16'hC000;
        img[3] = 16'hABCD;
        load_img();
        rst = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("rstwb_r2", dut.r_rf[2], 32'h0);
        chk("rstwb_r1", dut.r_rf[1], 32'h0);
        chk("rstwb_pc", dbg_pc, 32'h0);
        chk("rstwb_halted", halted, 32'h0);
        chk("rstwb_mem_kept", dut.r_mem[3], 32'hABCD);
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_pc     = '0;
        m_halted = 1'b0;
        rst = 1'b0;
        run_instr(3, "rerun");
        chk("rerun_r2", dut.r_rf[2], 32'hABCD);
        cmp_all("rerun");

        // Random programs; loader pokes with rst low must be ignored
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 128; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'hC && w[0]) w[15:12] = 4'hF;
                img[i] = w;
            end
            load_img();
            ld_we   = 1'b1;
            ld_addr = 7'($urandom);
            ld_data = 16'($urandom);
            rst = 1'b0;
            run_instr(60, "rnd");
            ld_we = 1'b0;
            cmp_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
